// File: rtl/revers_cnt_bcd_multi.sv
// rtl/revers_cnt_bcd_multi.sv - multi-digit reversible BCD counter with load, enable and up/down FSM
// Optional build macro REVERS_CNT_BCD_WRAP_EN: wrap at the boundary instead of saturating in LIMIT.
module revers_cnt_bcd_multi #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  load,
    input  logic                  en,
    input  logic                  revers,
    input  logic [4*DIGITS-1:0]   data,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  tc,
    output logic                  err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UP    = 2'd1,
        DN    = 2'd2,
        LIMIT = 2'd3
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_q;
    logic           r_tc;
    logic           r_err;

    logic [W-1:0]   w_sanit;
    logic           w_load_err;
    logic [W-1:0]   w_inc;
    logic [W-1:0]   w_dec;
    logic           w_all9;
    logic           w_all0;
    logic           w_at_bound;
    logic [W-1:0]   w_step;
    state_t         w_dir_state;

    // Load sanitizer: any digit above 9 is clamped to 9 and flagged.
    always_comb begin
        logic [3:0] v_nib;
        w_sanit    = '0;
        w_load_err = 1'b0;
        v_nib      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            v_nib = data[i*4 +: 4];
            if (v_nib > 4'd9) begin
                w_sanit[i*4 +: 4] = 4'd9;
                w_load_err        = 1'b1;
            end else begin
                w_sanit[i*4 +: 4] = v_nib;
            end
        end
    end

    // Decimal ripple carry/borrow; the final carry/borrow doubles as the boundary detect.
    always_comb begin
        logic [3:0] v_nib;
        logic       v_cy;
        logic       v_bw;
        w_inc  = '0;
        w_dec  = '0;
        v_nib  = 4'd0;
        v_cy   = 1'b1;
        v_bw   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            v_nib = r_q[i*4 +: 4];
            if (v_cy) begin
                w_inc[i*4 +: 4] = (v_nib == 4'd9) ? 4'd0 : 4'(v_nib + 4'd1);
            end else begin
                w_inc[i*4 +: 4] = v_nib;
            end
            if (v_bw) begin
                w_dec[i*4 +: 4] = (v_nib == 4'd0) ? 4'd9 : 4'(v_nib - 4'd1);
            end else begin
                w_dec[i*4 +: 4] = v_nib;
            end
            v_cy = v_cy && (v_nib == 4'd9);
            v_bw = v_bw && (v_nib == 4'd0);
        end
        w_all9 = v_cy;
        w_all0 = v_bw;
    end

    assign w_at_bound  = revers ? w_all0 : w_all9;
    assign w_step      = revers ? w_dec : w_inc;
    assign w_dir_state = revers ? DN : UP;

    always_ff @(posedge clk) begin
        if (!res) begin
            r_q     <= '0;
            r_tc    <= 1'b0;
            r_err   <= 1'b0;
            r_state <= IDLE;
        end else if (load) begin
            r_q     <= w_sanit;
            r_err   <= w_load_err;
            r_tc    <= 1'b0;
            r_state <= IDLE;
        end else if (en) begin
            case (r_state)
                // Q can only sit on one boundary, so "same direction" means still at a boundary.
                LIMIT: begin
                    if (w_at_bound) begin
                        r_tc <= 1'b0;
                    end else begin
                        r_q     <= w_step;
                        r_tc    <= 1'b0;
                        r_state <= w_dir_state;
                    end
                end
                default: begin
                    if (w_at_bound) begin
`ifdef REVERS_CNT_BCD_WRAP_EN
                        r_q     <= w_step;
                        r_tc    <= 1'b1;
                        r_state <= w_dir_state;
`else
                        r_tc    <= 1'b1;
                        r_state <= LIMIT;
`endif
                    end else begin
                        r_q     <= w_step;
                        r_tc    <= 1'b0;
                        r_state <= w_dir_state;
                    end
                end
            endcase
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign Q   = r_q;
    assign tc  = r_tc;
    assign err = r_err;

endmodule
